// File: rtl/reg_file_sb.sv
// Architectural register file (R0 hardwired zero) with write-back bypass on
// both read ports and a busy scoreboard used by decode for RAW/WAW stalls.
module reg_file_sb #(
  parameter int unsigned N   = 16,
  parameter int unsigned SEL = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wb_en,
  input  logic [SEL-1:0] rd_sel,
  input  logic [N-1:0]   rd_val,
  input  logic [SEL-1:0] rs1_sel,
  input  logic [SEL-1:0] rs2_sel,
  output logic [N-1:0]   rs1_val,
  output logic [N-1:0]   rs2_val,
  input  logic           iss_en,
  input  logic [SEL-1:0] iss_rd,
  output logic           rs1_busy,
  output logic           rs2_busy,
  output logic           stall,
  output logic           iss_ack
);

  localparam int unsigned DEPTH = 2 ** SEL;

  logic [N-1:0]     regs_q [DEPTH];
  logic [N-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wb_hit_rs1;
  logic wb_hit_rs2;
  logic wb_hit_iss;
  logic waw;

  always_comb begin
    wb_hit_rs1 = wb_en && (rd_sel == rs1_sel);
    wb_hit_rs2 = wb_en && (rd_sel == rs2_sel);
    wb_hit_iss = wb_en && (rd_sel == iss_rd);

    rs1_val = '0;
    if (rs1_sel != '0) begin
      rs1_val = wb_hit_rs1 ? rd_val : regs_q[rs1_sel];
    end
    rs2_val = '0;
    if (rs2_sel != '0) begin
      rs2_val = wb_hit_rs2 ? rd_val : regs_q[rs2_sel];
    end

    // A value arriving this cycle resolves the hazard in the same cycle.
    rs1_busy = (rs1_sel != '0) && busy_q[rs1_sel] && !wb_hit_rs1;
    rs2_busy = (rs2_sel != '0) && busy_q[rs2_sel] && !wb_hit_rs2;
    waw      = (iss_rd != '0) && busy_q[iss_rd] && !wb_hit_iss;

    stall   = iss_en && (rs1_busy || rs2_busy || waw);
    iss_ack = iss_en && !stall;
  end

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_en && (rd_sel != '0)) begin
      regs_d[rd_sel] = rd_val;
      busy_d[rd_sel] = 1'b0;
    end
    // Set after clear: a newly issued producer owns the register.
    if (iss_ack && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

endmodule
